// File: rtl/vc_allocator.sv
// vc_allocator: central virtual-channel allocator for one router.
// Every requester (input port x VC) may ask for a VC on one output port.
// Each output picks one winner per cycle by round-robin and hands it the
// lowest free VC. Per-output occupancy is tracked until a downstream release.
// Optional feature macro: VC_ALLOC_REL_BYPASS_EN (a VC released this cycle
// is visible as free to this cycle's allocation).
module vc_allocator #(
  parameter int NUM_IN  = 5,
  parameter int NUM_OUT = 5,
  parameter int VC_NUM  = 2,
  parameter int PORT_W  = 3,
  localparam int VC_W    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int NUM_REQ = NUM_IN * VC_NUM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        vc_req_i,
  input  logic [NUM_REQ*PORT_W-1:0] out_port_i,
  output logic [NUM_REQ-1:0]        vc_val_o,
  output logic [NUM_REQ*VC_W-1:0]   vc_new_o,
  input  logic [NUM_OUT-1:0]        rel_i,
  input  logic [NUM_OUT*VC_W-1:0]   rel_vc_i,
  output logic [NUM_OUT*VC_NUM-1:0] vc_busy_o,
  output logic                      err_o
);

  localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        r_val;
  logic [NUM_REQ*VC_W-1:0]   r_new;
  logic [NUM_OUT*VC_NUM-1:0] r_busy;
  logic                      r_err;
  logic [REQ_W-1:0]          r_ptr [NUM_OUT];

  logic [NUM_REQ-1:0]        w_gnt      [NUM_OUT];
  logic [VC_W-1:0]           w_gnt_vc   [NUM_OUT];
  logic [VC_NUM-1:0]         w_set      [NUM_OUT];
  logic [VC_NUM-1:0]         w_clr      [NUM_OUT];
  logic [REQ_W-1:0]          w_ptr_next [NUM_OUT];
  logic [NUM_OUT-1:0]        w_rel_err;
  logic [NUM_REQ-1:0]        w_port_err;
  logic [NUM_REQ-1:0]        w_val_next;
  logic [NUM_REQ*VC_W-1:0]   w_new_next;
  logic [NUM_OUT*VC_NUM-1:0] w_busy_next;

  // A request naming a non-existent output is flagged and never becomes a candidate.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_port_err[gi] = vc_req_i[gi] &&
                              (int'(out_port_i[gi*PORT_W +: PORT_W]) >= NUM_OUT);
    end

    for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
      logic [VC_NUM-1:0]  w_rel_dec;
      logic               w_rel_ok;
      logic [VC_NUM-1:0]  w_free;
      logic [NUM_REQ-1:0] w_cand;
      logic               w_have_win;
      logic [REQ_W-1:0]   w_win;
      logic               w_have_vc;
      logic [VC_W-1:0]    w_vc;
      logic               w_fire;

      // Decode the released VC; an out-of-range code decodes to nothing.
      always_comb begin
        w_rel_dec = '0;
        for (int v = 0; v < VC_NUM; v++) begin
          if (int'(rel_vc_i[gi*VC_W +: VC_W]) == v) w_rel_dec[v] = 1'b1;
        end
      end

      // A release is legal only when it targets a VC that is currently busy.
      assign w_rel_ok       = rel_i[gi] && |(w_rel_dec & r_busy[gi*VC_NUM +: VC_NUM]);
      assign w_rel_err[gi]  = rel_i[gi] && !w_rel_ok;
      assign w_clr[gi]      = w_rel_ok ? w_rel_dec : '0;

`ifdef VC_ALLOC_REL_BYPASS_EN
      assign w_free = ~r_busy[gi*VC_NUM +: VC_NUM] | w_clr[gi];
`else
      assign w_free = ~r_busy[gi*VC_NUM +: VC_NUM];
`endif

      // Candidates: requesting, aimed at this output, and not granted last cycle.
      always_comb begin
        w_cand = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
          if (vc_req_i[r] && !r_val[r] &&
              (int'(out_port_i[r*PORT_W +: PORT_W]) == gi)) w_cand[r] = 1'b1;
        end
      end

      // Round-robin search starting at this output's pointer.
      always_comb begin
        w_have_win = 1'b0;
        w_win      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!w_have_win && w_cand[(int'(r_ptr[gi]) + k) % NUM_REQ]) begin
            w_have_win = 1'b1;
            w_win      = REQ_W'((int'(r_ptr[gi]) + k) % NUM_REQ);
          end
        end
      end

      // Lowest-index free VC on this output.
      always_comb begin
        w_have_vc = 1'b0;
        w_vc      = '0;
        for (int v = 0; v < VC_NUM; v++) begin
          if (!w_have_vc && w_free[v]) begin
            w_have_vc = 1'b1;
            w_vc      = VC_W'(v);
          end
        end
      end

      assign w_fire         = w_have_win && w_have_vc;
      assign w_gnt[gi]      = w_fire ? (NUM_REQ'(1) << w_win) : '0;
      assign w_gnt_vc[gi]   = w_vc;
      assign w_set[gi]      = w_fire ? (VC_NUM'(1) << w_vc) : '0;
      assign w_ptr_next[gi] = !w_fire ? r_ptr[gi] :
                              (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + REQ_W'(1);
    end
  endgenerate

  // Merge per-output decisions into per-requester grants and the next occupancy map.
  always_comb begin
    w_val_next  = '0;
    w_new_next  = r_new;
    w_busy_next = r_busy;
    for (int o = 0; o < NUM_OUT; o++) begin
      w_val_next = w_val_next | w_gnt[o];
      // Set wins over clear so a bypassed release-and-regrant leaves the VC busy.
      w_busy_next[o*VC_NUM +: VC_NUM] = (r_busy[o*VC_NUM +: VC_NUM] & ~w_clr[o]) | w_set[o];
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      for (int o = 0; o < NUM_OUT; o++) begin
        if (w_gnt[o][r]) w_new_next[r*VC_W +: VC_W] = w_gnt_vc[o];
      end
    end
  end

  // State register: grants, granted VCs, occupancy, error pulse and RR pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_val  <= '0;
      r_new  <= '0;
      r_busy <= '0;
      r_err  <= 1'b0;
      for (int o = 0; o < NUM_OUT; o++) r_ptr[o] <= '0;
    end else begin
      r_val  <= w_val_next;
      r_new  <= w_new_next;
      r_busy <= w_busy_next;
      r_err  <= (|w_rel_err) || (|w_port_err);
      for (int o = 0; o < NUM_OUT; o++) r_ptr[o] <= w_ptr_next[o];
    end
  end

  assign vc_val_o  = r_val;
  assign vc_new_o  = r_new;
  assign vc_busy_o = r_busy;
  assign err_o     = r_err;

endmodule

// File: tb/tb_vc_allocator.sv
// Self-checking bench for vc_allocator: a queue-based model of the allocation
// rules is stepped every cycle and compared against the DUT, and directed
// scenarios additionally pin hand-computed literal values.
module tb_vc_allocator;

  localparam int NUM_IN  = 5;
  localparam int NUM_OUT = 5;
  localparam int VC_NUM  = 2;
  localparam int PORT_W  = 3;
  localparam int VC_W    = 1;
  localparam int NUM_REQ = NUM_IN * VC_NUM;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        vc_req_i;
  logic [NUM_REQ*PORT_W-1:0] out_port_i;
  logic [NUM_REQ-1:0]        vc_val_o;
  logic [NUM_REQ*VC_W-1:0]   vc_new_o;
  logic [NUM_OUT-1:0]        rel_i;
  logic [NUM_OUT*VC_W-1:0]   rel_vc_i;
  logic [NUM_OUT*VC_NUM-1:0] vc_busy_o;
  logic                      err_o;

  vc_allocator #(
    .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .VC_NUM(VC_NUM), .PORT_W(PORT_W)
  ) u_dut (
    .clk(clk), .rst(rst), .vc_req_i(vc_req_i), .out_port_i(out_port_i),
    .vc_val_o(vc_val_o), .vc_new_o(vc_new_o), .rel_i(rel_i), .rel_vc_i(rel_vc_i),
    .vc_busy_o(vc_busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Model state
  bit m_busy [NUM_OUT][VC_NUM];
  int m_ptr  [NUM_OUT];
  bit m_val  [NUM_REQ];
  int m_new  [NUM_REQ];
  bit m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int port_of(input int r);
    return int'(out_port_i[r*PORT_W +: PORT_W]);
  endfunction

  // Compute what the registered outputs must be after the coming edge.
  task automatic model_step();
    bit n_val  [NUM_REQ];
    bit rel_ok [NUM_OUT];
    int rv     [NUM_OUT];
    int gw     [NUM_OUT];
    int gv     [NUM_OUT];
    bit err;
    if (rst) begin
      for (int o = 0; o < NUM_OUT; o++) begin
        m_ptr[o] = 0;
        for (int v = 0; v < VC_NUM; v++) m_busy[o][v] = 0;
      end
      for (int r = 0; r < NUM_REQ; r++) begin m_val[r] = 0; m_new[r] = 0; end
      m_err = 0;
      return;
    end
    err = 0;
    for (int o = 0; o < NUM_OUT; o++) begin
      rv[o] = int'(rel_vc_i[o*VC_W +: VC_W]);
      rel_ok[o] = 0;
      if (rel_i[o]) begin
        if (rv[o] < VC_NUM && m_busy[o][rv[o]]) rel_ok[o] = 1;
        else err = 1;
      end
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      n_val[r] = 0;
      if (vc_req_i[r] && port_of(r) >= NUM_OUT) err = 1;
    end
    for (int o = 0; o < NUM_OUT; o++) begin
      int freeq[$];
      int pend[$];
      freeq.delete();
      pend.delete();
      gw[o] = -1;
      gv[o] = -1;
      for (int v = 0; v < VC_NUM; v++) begin
        bit avail;
        avail = !m_busy[o][v];
`ifdef VC_ALLOC_REL_BYPASS_EN
        if (rel_ok[o] && rv[o] == v) avail = 1;
`endif
        if (avail) freeq.push_back(v);
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        int r;
        r = (m_ptr[o] + k) % NUM_REQ;
        if (vc_req_i[r] && port_of(r) == o && !m_val[r]) pend.push_back(r);
      end
      if (pend.size() > 0 && freeq.size() > 0) begin
        gw[o] = pend[0];
        gv[o] = freeq[0];
      end
    end
    for (int o = 0; o < NUM_OUT; o++) begin
      if (rel_ok[o]) m_busy[o][rv[o]] = 0;
      if (gw[o] >= 0) begin
        m_busy[o][gv[o]] = 1;
        m_ptr[o] = (gw[o] + 1) % NUM_REQ;
        n_val[gw[o]] = 1;
        m_new[gw[o]] = gv[o];
      end
    end
    for (int r = 0; r < NUM_REQ; r++) m_val[r] = n_val[r];
    m_err = err;
  endtask

  task automatic compare();
    logic [NUM_REQ-1:0]        ev;
    logic [NUM_REQ*VC_W-1:0]   en;
    logic [NUM_OUT*VC_NUM-1:0] eb;
    for (int r = 0; r < NUM_REQ; r++) begin
      ev[r] = m_val[r];
      en[r*VC_W +: VC_W] = VC_W'(m_new[r]);
    end
    for (int o = 0; o < NUM_OUT; o++)
      for (int v = 0; v < VC_NUM; v++) eb[o*VC_NUM+v] = m_busy[o][v];
    check("model_vc_val",  32'(vc_val_o),  32'(ev));
    check("model_vc_new",  32'(vc_new_o),  32'(en));
    check("model_vc_busy", 32'(vc_busy_o), 32'(eb));
    check("model_err",     32'(err_o),     32'(m_err));
  endtask

  // One clock: step the model with current inputs, take the edge, compare, log.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare();
    $display("cyc %0d rst=%0b req=%b rel=%b val=%b new=%b busy=%b err=%b",
             cyc, rst, vc_req_i, rel_i, vc_val_o, vc_new_o, vc_busy_o, err_o);
    rel_i = '0;
  endtask

  task automatic req(input int r, input int p);
    vc_req_i[r] = 1'b1;
    out_port_i[r*PORT_W +: PORT_W] = PORT_W'(p);
  endtask

  task automatic unreq(input int r);
    vc_req_i[r] = 1'b0;
  endtask

  task automatic release_vc(input int o, input int v);
    rel_i[o] = 1'b1;
    rel_vc_i[o*VC_W +: VC_W] = VC_W'(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vc_req_i = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    vc_req_i   = '0;
    out_port_i = '0;
    rel_i      = '0;
    rel_vc_i   = '0;
    tick();
    tick();
    check("reset_busy", 32'(vc_busy_o), 32'h0);
    check("reset_val",  32'(vc_val_o),  32'h0);
    check("reset_err",  32'(err_o),     32'h0);
    rst = 1'b0;

    // Single request: r0 -> port 2
    req(0, 2);
    tick();
    check("single_val",  32'(vc_val_o),    32'h001);
    check("single_vc",   32'(vc_new_o[0]), 32'h0);
    check("single_busy", 32'(vc_busy_o),   32'h010);
    tick();
    check("single_mask", 32'(vc_val_o),    32'h000);
    unreq(0);
    release_vc(2, 0);
    tick();
    check("single_rel_busy", 32'(vc_busy_o), 32'h000);

    // Contention on port 4
    req(1, 4); req(3, 4); req(5, 4);
    tick();
    check("cont_r1_val", 32'(vc_val_o), 32'h002);
    check("cont_r1_vc",  32'(vc_new_o[1]), 32'h0);
    unreq(1);
    tick();
    check("cont_r3_val", 32'(vc_val_o), 32'h008);
    check("cont_r3_vc",  32'(vc_new_o[3]), 32'h1);
    check("cont_full",   32'(vc_busy_o), 32'h300);
    unreq(3);
    tick();
    check("cont_stall1", 32'(vc_val_o), 32'h000);
    tick();
    check("cont_stall2", 32'(vc_val_o), 32'h000);
    release_vc(4, 0);
    tick();
`ifdef VC_ALLOC_REL_BYPASS_EN
    check("cont_r5_val",  32'(vc_val_o), 32'h020);
    check("cont_r5_busy", 32'(vc_busy_o), 32'h300);
`else
    check("cont_gap_val",  32'(vc_val_o), 32'h000);
    check("cont_gap_busy", 32'(vc_busy_o), 32'h200);
    tick();
    check("cont_r5_val",  32'(vc_val_o), 32'h020);
    check("cont_r5_busy", 32'(vc_busy_o), 32'h300);
`endif
    check("cont_r5_vc", 32'(vc_new_o[5]), 32'h0);
    unreq(5);
    do_reset();

    // Round-robin fairness on port 1 with releases each cycle
    req(2, 1); req(6, 1);
    tick();
    check("rr_a", 32'(vc_val_o), 32'h004);
    release_vc(1, 0);
    tick();
    check("rr_b", 32'(vc_val_o), 32'h040);
    release_vc(1, 1);
    tick();
    check("rr_c", 32'(vc_val_o), 32'h004);
    release_vc(1, 0);
    tick();
    check("rr_d", 32'(vc_val_o), 32'h040);
    release_vc(1, 1);
    tick();
    unreq(2); unreq(6);
    do_reset();

    // Parallel outputs
    req(0, 0); req(9, 3);
    tick();
    check("par_val",  32'(vc_val_o),  32'h201);
    check("par_busy", 32'(vc_busy_o), 32'h041);
    unreq(0); unreq(9);

    // Errors: release of a free VC, then request to a bad port
    release_vc(1, 1);
    tick();
    check("err_rel",      32'(err_o),     32'h1);
    check("err_rel_busy", 32'(vc_busy_o), 32'h041);
    tick();
    check("err_clear", 32'(err_o), 32'h0);
    req(4, 7);
    tick();
    check("err_port",     32'(err_o),    32'h1);
    check("err_port_val", 32'(vc_val_o), 32'h000);
    unreq(4);
    tick();
    check("err_port_clear", 32'(err_o), 32'h0);

    // Fill every VC, then reset mid-operation
    do_reset();
    for (int r = 0; r < NUM_REQ; r++) req(r, r / 2);
    tick();
    check("fill_1", 32'(vc_val_o), 32'h155);
    tick();
    check("fill_2", 32'(vc_val_o), 32'h2AA);
    tick();
    check("fill_full_val",  32'(vc_val_o),  32'h000);
    check("fill_full_busy", 32'(vc_busy_o), 32'h3FF);
    rst = 1'b1;
    tick();
    check("midrst_busy", 32'(vc_busy_o), 32'h000);
    check("midrst_val",  32'(vc_val_o),  32'h000);
    rst = 1'b0;
    vc_req_i = '0;
    req(1, 2); req(7, 2);
    tick();
    check("midrst_ptr", 32'(vc_val_o), 32'h002);
    vc_req_i = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
